seq_bus_uart: RTL and testbench

- Memory-mapped 8N1 UART peripheral on the CPU's data bus, directly downstream of the CPU.
- Decodes `address`, `wren_n` and `oen_n`, and returns read data on `data_in`.
- TX path has a FIFO; RX path has a single holding register.
- `rdata` is driven to 0 when this block is not selected, so the top level can OR it with RAM and other peripherals.

---
 rtl/seq_bus_uart.sv | 182 ++++++++++++++++++
 tb/tb_seq_bus_uart.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_bus_uart.sv
// seq_bus_uart: memory-mapped 8N1 UART with a TX FIFO and an RX holding register.
// Ports: clk, rst_n (async active-low); address/wdata/wren_n/oen_n CPU bus;
//        rdata read data (0 when not selected, OR-able); txd/rxd serial lines;
//        irq = rx_valid | tx_empty (registered).
module seq_bus_uart #(
   parameter logic [15:0] BASE_ADDR  = 16'hFF00,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] address,
   input  logic [15:0] wdata,
   input  logic        wren_n,
   input  logic        oen_n,
   output logic [15:0] rdata,
   output logic        txd,
   input  logic        rxd,
   output logic        irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;
   logic sel, rd, rd_first, rd_data_first, rd_stat_first, wr_data, prev_oen_n;
   logic unused_hi;
   assign unused_hi = ^wdata[15:8];
   assign sel = address[15:1] == BASE_ADDR[15:1];
   assign rd = sel & ~oen_n;
   // read side effects fire only on the first cycle of an oen_n-low run
   assign rd_first = rd & prev_oen_n;
   assign rd_data_first = rd_first & ~address[0];
   assign rd_stat_first = rd_first & address[0];
   assign wr_data = sel & ~wren_n & ~address[0];
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW:0] wp, rp, wp_n, rp_n;
   logic full, empty, push, pop;
   assign empty = wp == rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   // a pop in the same cycle frees a slot, so a push into a full FIFO still lands
   assign push = wr_data & (~full | pop);
   assign wp_n = wp + {{AW{1'b0}}, push};
   assign rp_n = rp + {{AW{1'b0}}, pop};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         wp <= wp_n;
         rp <= rp_n;
      end
   always_ff @(posedge clk)
      if (push) mem[wp[AW-1:0]] <= wdata[7:0];
   st_t tx_st, tx_nx;
   logic [15:0] tx_cnt, tx_cnt_n;
   logic [2:0] tx_bit, tx_bit_n;
   logic [7:0] tx_sh, tx_sh_n;
   logic tx_busy;
   assign tx_busy = tx_st != IDLE;
   always_comb begin
      tx_nx = tx_st;
      tx_cnt_n = tx_cnt - 16'd1;
      tx_bit_n = tx_bit;
      tx_sh_n = tx_sh;
      pop = 1'b0;
      case (tx_st)
         IDLE: begin
            tx_cnt_n = DIV_M1;
            pop = ~empty;
         end
         START: if (tx_cnt == '0) begin
            tx_nx = DATA;
            tx_cnt_n = DIV_M1;
            tx_bit_n = 3'd0;
         end
         DATA: if (tx_cnt == '0) begin
            tx_cnt_n = DIV_M1;
            tx_sh_n = tx_sh >> 1;
            tx_bit_n = tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_nx = STOP;
         end
         STOP: if (tx_cnt == '0) begin
            tx_cnt_n = DIV_M1;
            tx_nx = IDLE;
            pop = ~empty;
         end
         default: tx_nx = IDLE;
      endcase
      // popping from IDLE or the last STOP cycle chains frames with no idle gap
      if (pop) begin
         tx_sh_n = mem[rp[AW-1:0]];
         tx_nx = START;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tx_st <= IDLE;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh <= '0;
         txd <= 1'b1;
      end else begin
         tx_st <= tx_nx;
         tx_cnt <= tx_cnt_n;
         tx_bit <= tx_bit_n;
         tx_sh <= tx_sh_n;
         txd <= (tx_st == START) ? 1'b0 : (tx_st == DATA) ? tx_sh[0] : 1'b1;
      end
   logic s1, s2, s3, fall;
   assign fall = s3 & ~s2;
   st_t rx_st, rx_nx;
   logic [15:0] rx_cnt, rx_cnt_n;
   logic [2:0] rx_bit, rx_bit_n;
   logic [7:0] rx_sh, rx_sh_n, rx_byte;
   logic rx_done, rx_ferr, rx_valid, rv_n, take, overrun, frame_err;
   always_comb begin
      rx_nx = rx_st;
      rx_cnt_n = rx_cnt - 16'd1;
      rx_bit_n = rx_bit;
      rx_sh_n = rx_sh;
      rx_done = 1'b0;
      rx_ferr = 1'b0;
      case (rx_st)
         IDLE: begin
            rx_cnt_n = HALF_M1;
            if (fall) rx_nx = START;
         end
         START: if (rx_cnt == '0) begin
            rx_cnt_n = DIV_M1;
            rx_bit_n = 3'd0;
            rx_nx = s2 ? IDLE : DATA;
         end
         DATA: if (rx_cnt == '0) begin
            rx_cnt_n = DIV_M1;
            rx_sh_n = {s2, rx_sh[7:1]};
            rx_bit_n = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_nx = STOP;
         end
         STOP: if (rx_cnt == '0) begin
            rx_nx = IDLE;
            rx_done = s2;
            rx_ferr = ~s2;
         end
         default: rx_nx = IDLE;
      endcase
   end
   // a completion coinciding with a DATA-read clear loads the new byte, no overrun
   assign take = rx_done & (~rx_valid | rd_data_first);
   assign rv_n = take | (rx_valid & ~rd_data_first);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
         rx_st <= IDLE;
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_sh <= '0;
         rx_byte <= '0;
         rx_valid <= 1'b0;
         overrun <= 1'b0;
         frame_err <= 1'b0;
         irq <= 1'b1;
         prev_oen_n <= 1'b1;
      end else begin
         s1 <= rxd;
         s2 <= s1;
         s3 <= s2;
         rx_st <= rx_nx;
         rx_cnt <= rx_cnt_n;
         rx_bit <= rx_bit_n;
         rx_sh <= rx_sh_n;
         rx_byte <= take ? rx_sh : rx_byte;
         rx_valid <= rv_n;
         overrun <= (rx_done & ~take) | (overrun & ~rd_stat_first);
         frame_err <= rx_ferr | (frame_err & ~rd_stat_first);
         irq <= rv_n | (wp_n == rp_n);
         prev_oen_n <= oen_n;
      end
   assign rdata = ~rd ? '0 : address[0] ? {10'b0, frame_err, overrun, rx_valid, tx_busy, empty, full}
                                        : {8'h00, rx_byte};
endmodule

// File: tb/tb_seq_bus_uart.sv
// tb_seq_bus_uart: directed bench for seq_bus_uart (CLK_DIV=16, FIFO_DEPTH=4).
module tb_seq_bus_uart;
   localparam logic [15:0] DA = 16'hFF00;
   localparam logic [15:0] ST = 16'hFF01;
   logic clk, rst_n, wren_n, oen_n, txd, rxd, irq;
   logic [15:0] address, wdata, rdata, v;
   int checks = 0, errors = 0;
   logic samp [1000];
   logic [7:0] wb [5];
   int fl, busy_cnt, last_busy;
   logic full_seen, irq_w;
   seq_bus_uart dut (
      .clk(clk), .rst_n(rst_n), .address(address), .wdata(wdata), .wren_n(wren_n),
      .oen_n(oen_n), .rdata(rdata), .txd(txd), .rxd(rxd), .irq(irq)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask
   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      address = a;
      wdata = d;
      wren_n = 1'b0;
      @(negedge clk);
      wren_n = 1'b1;
   endtask
   task automatic rd(input logic [15:0] a, output logic [15:0] d);
      @(negedge clk);
      address = a;
      oen_n = 1'b0;
      #1 d = rdata;
      @(negedge clk);
      oen_n = 1'b1;
   endtask
   task automatic rx_send(input logic [7:0] b, input logic stop);
      @(negedge clk) rxd = 1'b0;
      repeat (15) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk) rxd = b[i];
         repeat (15) @(negedge clk);
      end
      @(negedge clk) rxd = stop;
      repeat (15) @(negedge clk);
      @(negedge clk) rxd = 1'b1;
      repeat (8) @(negedge clk);
   endtask
   task automatic tx_run(input int n);
      @(negedge clk);
      address = DA;
      wdata = {8'h12, wb[0]};
      wren_n = 1'b0;
      busy_cnt = 0;
      last_busy = 0;
      full_seen = 1'b0;
      irq_w = 1'bx;
      for (int k = 1; k < 1000; k++) begin
         @(negedge clk);
         if (k < n) wdata = {8'h12, wb[k]};
         else begin
            wren_n = 1'b1;
            address = ST;
            oen_n = 1'b0;
         end
         #1 samp[k] = txd;
         if (k == n) irq_w = irq;
         if (k >= n && rdata[2]) begin
            busy_cnt++;
            last_busy = k;
         end
         if (k >= n && rdata[0]) full_seen = 1'b1;
      end
      oen_n = 1'b1;
      fl = 0;
      for (int k = 999; k >= 1; k--) if (samp[k] === 1'b0) fl = k;
   endtask
   function automatic logic [9:0] frame(input int f);
      logic [9:0] r;
      for (int j = 0; j < 10; j++) r[j] = samp[fl + 8 + 16 * (10 * f + j)];
      return r;
   endfunction
   initial begin
      rst_n = 1'b0;
      rxd = 1'b1;
      address = '0;
      wdata = '0;
      wren_n = 1'b1;
      oen_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_txd", txd, 1);
      chk("rst_irq", irq, 1);
      chk("rst_rdata", rdata, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      rd(ST, v);
      chk("stat_reset", v, 16'h0002);
      wb[0] = 8'h55;
      tx_run(1);
      chk("tx1_first_low", fl, 3);
      chk("tx1_busy_cycles", busy_cnt, 160);
      chk("tx1_frame", frame(0), 10'h2AA);
      chk("tx1_irq_pending", irq_w, 0);
      chk("tx1_no_full", full_seen, 0);
      rd(ST, v);
      chk("tx1_stat_done", v, 16'h0002);
      wb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
      tx_run(5);
      chk("burst_first_low", fl, 3);
      chk("burst_last_busy", last_busy, 801);
      chk("burst_full_seen", full_seen, 1);
      chk("burst_irq_pending", irq_w, 0);
      for (int f = 0; f < 5; f++) chk($sformatf("burst_frame%0d", f), frame(f), {1'b1, wb[f], 1'b0});
      rx_send(8'h3C, 1'b1);
      rd(ST, v);
      chk("rx_stat_valid", v, 16'h000A);
      chk("rx_irq", irq, 1);
      rd(DA, v);
      chk("rx_data", v, 16'h003C);
      rd(ST, v);
      chk("rx_stat_cleared", v, 16'h0002);
      rx_send(8'h11, 1'b1);
      rx_send(8'h22, 1'b1);
      rd(DA, v);
      chk("ovr_data", v, 16'h0011);
      rd(ST, v);
      chk("ovr_stat_set", v, 16'h0012);
      rd(ST, v);
      chk("ovr_stat_clr", v, 16'h0002);
      rx_send(8'h5A, 1'b0);
      rd(ST, v);
      chk("ferr_stat_set", v, 16'h0022);
      rd(ST, v);
      chk("ferr_stat_clr", v, 16'h0002);
      rd(DA, v);
      chk("ferr_byte_kept", v, 16'h0011);
      @(negedge clk) rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      rd(ST, v);
      chk("glitch_stat", v, 16'h0002);
      rx_send(8'h96, 1'b1);
      rd(DA, v);
      chk("glitch_then_rx", v, 16'h0096);
      wr(DA, 16'h0000);
      wr(DA, 16'h00F0);
      repeat (40) @(negedge clk);
      chk("mid_frame_txd", txd, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_txd", txd, 1);
      chk("mid_rst_irq", irq, 1);
      @(negedge clk) rst_n = 1'b1;
      rd(ST, v);
      chk("mid_rst_stat", v, 16'h0002);
      repeat (40) @(negedge clk);
      chk("mid_rst_idle", txd, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
